sys_xbus_regfile: RTL and testbench
===================================

// Module: sys_xbus_regfile
// PURPOSE
// Parametrised Wishbone-classic register file for the RISC-V system bus (xbus).
// Provides NUM_RD read-only status words, NUM_WR read/write control words with reset values and
// per-word write strobes, and a W1C interrupt status/enable pair driving one level IRQ.
// Unmapped accesses terminate with err_o. Sits between the xbus interconnect and fabric datapath blocks.
// PARAMETERS
// NUM_RD       16            read-only status words, 1..64
// NUM_WR       28            read/write control words, 1..64
// NUM_IRQ      8             interrupt source bits, 1..DATA_WIDTH
// ADDR_WIDTH   32            bus address width
// DATA_WIDTH   32            bus data width: 8, 16, 32 or 64
// SELECT_WIDTH DATA_WIDTH/8  byte-select width
// BASE_ADDR    32'h10000000  byte address of word 0
// WR_OFFSET    64            word index of first control word; must be >= NUM_RD
// IRQ_OFFSET   128           word index of IRQ_STATUS; IRQ_ENABLE is at IRQ_OFFSET+1
// WR_RST_VAL   0             NUM_WR*DATA_WIDTH flattened reset values; word k is at [k*DATA_WIDTH +: DATA_WIDTH]
// PORTS
// clk        in   1                    system clock
// rst_n      in   1                    synchronous reset, active low
// adr_i      in   ADDR_WIDTH           byte address
// dat_i      in   DATA_WIDTH           write data
// we_i       in   1                    write enable
// sel_i      in   SELECT_WIDTH         byte lane select
// stb_i      in   1                    strobe
// cyc_i      in   1                    cycle
// dat_o      out  DATA_WIDTH           read data, registered
// ack_o      out  1                    normal termination
// err_o      out  1                    error termination, unmapped address
// o_wr_regs  out  NUM_WR*DATA_WIDTH    control words, flattened
// o_wr_stb   out  NUM_WR               1-cycle pulse per control word written
// i_rd_regs  in   NUM_RD*DATA_WIDTH    status words, flattened
// i_irq      in   NUM_IRQ              interrupt set pulses/levels, sampled every cycle
// o_irq      out  1                    |(status & enable), registered
// BEHAVIOUR
// - Reset (rst_n=0 at clk edge): o_wr_regs=WR_RST_VAL, status=0, enable=0; dat_o, ack_o, err_o,
//   o_wr_stb and o_irq all 0. An in-flight access is dropped: no write, no termination.
// - Word index: w = (adr_i - BASE_ADDR) >> log2(SELECT_WIDTH), computed at full ADDR_WIDTH.
//   An address below BASE_ADDR wraps to a large w and is therefore unmapped.
// - Map: [0,NUM_RD) RO; [WR_OFFSET, WR_OFFSET+NUM_WR) RW; IRQ_OFFSET STATUS (W1C);
//   IRQ_OFFSET+1 ENABLE (RW, only bits < NUM_IRQ). Anything else is unmapped.
// - Access accepted when cyc_i & stb_i & ~ack_o & ~err_o. Exactly one termination follows,
//   1 cycle after acceptance. The termination is never back-to-back, so a held strobe gives
//   an accept every 2 cycles.
// - Mapped access: ack_o=1. Unmapped access: err_o=1, dat_o=0, no state change.
// - Writes honour sel_i per byte lane. Writes to RO words are ignored but still acked.
// - o_wr_stb[k] pulses in the same cycle as ack_o, only if at least one sel_i bit was set.
// - Reads return the value current at acceptance; control words and ENABLE read back.
//   STATUS read is not destructive. Reads with sel_i=0 still return the full word.
//   Bits >= NUM_IRQ read as 0.
// - STATUS: set each cycle where i_irq[b]=1. A W1C on bit b clears it.
//   Set and clear in the same cycle: set wins.
// - o_irq is registered, so it lags any status or enable change by 1 cycle.
// - Accesses with cyc_i=0 mid-cycle: no acceptance.
// STRUCTURE
// - Package sys_xbus_pkg: xbus_word_t, map-region enum (RGN_RD/RGN_WR/RGN_IRQ_ST/RGN_IRQ_EN/RGN_NONE),
//   decode function word_index(), default BASE_ADDR constant.
// - One sub-module, sys_xbus_irq_ctrl: holds STATUS/ENABLE, W1C logic and o_irq.
//   The top level keeps decode, bus FSM (IDLE->TERM->IDLE) and the control bank.
// TESTING
// - Reset release: read WR word 0 (adr 0x10000100), WR_RST_VAL[31:0]=0xA5A5_0001 -> ack, dat_o=0xA5A50001.
// - Write 0xDEADBEEF with sel=4'b0100 to 0x10000104 after reset 0 -> reads 0x00AD0000; o_wr_stb[1] pulses once.
// - Read adr 0x10000008 with i_rd_regs word2=0x1234 -> ack 1 cycle later, dat_o=0x1234.
//   Write there -> ack, no o_wr_stb.
// - Access 0x0FFFFFFC and 0x10000400 -> err_o=1, ack_o=0, dat_o=0; all registers unchanged.
// - i_irq[3] pulse, ENABLE=0x8 -> STATUS=0x8, o_irq=1. W1C 0x8 coincident with a new i_irq[3] pulse
//   -> STATUS stays 0x8. W1C alone -> o_irq=0 one cycle later.
// - cyc/stb held 6 cycles -> exactly 3 acks. rst_n low during TERM cycle -> no ack, write not applied.

Source files
------------

// File: rtl/sys_xbus_pkg.sv
// Shared types and address decode helpers for the xbus register file slice.
package sys_xbus_pkg;

  // Word-index container, wide enough for any supported bus address width.
  localparam int unsigned XBUS_IDX_W = 64;

  // Default byte address of word 0 on the xbus map.
  localparam logic [31:0] XBUS_DEFAULT_BASE = 32'h1000_0000;

  typedef logic [XBUS_IDX_W-1:0] xbus_word_t;

  // Region an access falls into after decode.
  typedef enum logic [2:0] {
    RGN_RD     = 3'd0,
    RGN_WR     = 3'd1,
    RGN_IRQ_ST = 3'd2,
    RGN_IRQ_EN = 3'd3,
    RGN_NONE   = 3'd4
  } xbus_rgn_t;

  // Word index of a byte address. The subtraction is truncated to the real
  // bus width first, so an address below the base wraps to a huge index and
  // lands outside every mapped region.
  function automatic xbus_word_t word_index(input xbus_word_t  adr,
                                            input xbus_word_t  base,
                                            input int unsigned aw,
                                            input int unsigned shift);
    xbus_word_t diff;
    xbus_word_t mask;
    diff = adr - base;
    if (aw >= XBUS_IDX_W) mask = '1;
    else                  mask = (xbus_word_t'(1) << aw) - xbus_word_t'(1);
    return (diff & mask) >> shift;
  endfunction

endpackage

// File: rtl/sys_xbus_irq_ctrl.sv
// Interrupt status/enable pair with write-one-to-clear status and a
// registered level interrupt output.
module sys_xbus_irq_ctrl
  import sys_xbus_pkg::*;
#(
  parameter int NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [NUM_IRQ-1:0] clr_i,
  input  logic               en_we_i,
  input  logic [NUM_IRQ-1:0] en_wdata_i,
  output logic [NUM_IRQ-1:0] status_o,
  output logic [NUM_IRQ-1:0] enable_o,
  output logic               irq_o
);

  logic [NUM_IRQ-1:0] status_q, status_d;
  logic [NUM_IRQ-1:0] enable_q, enable_d;
  logic               irq_q, irq_d;

  // Next status/enable: a new source pulse wins over a coincident clear.
  always_comb begin
    status_d = (status_q & ~clr_i) | irq_i;
    enable_d = en_we_i ? en_wdata_i : enable_q;
    irq_d    = |(status_q & enable_q);
  end

  // State registers; irq follows status/enable one cycle later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      status_q <= '0;
      enable_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      status_q <= status_d;
      enable_q <= enable_d;
      irq_q    <= irq_d;
    end
  end

  assign status_o = status_q;
  assign enable_o = enable_q;
  assign irq_o    = irq_q;

endmodule

// File: rtl/sys_xbus_regfile.sv
// Wishbone-classic register file on the xbus: read-only status words,
// read/write control words with write strobes, and an interrupt block.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | no access in flight; an asserted cyc/stb is accepted here
// ST_TERM | ack_o or err_o is high for exactly this cycle
module sys_xbus_regfile
  import sys_xbus_pkg::*;
#(
  parameter int NUM_RD       = 16,
  parameter int NUM_WR       = 28,
  parameter int NUM_IRQ      = 8,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(XBUS_DEFAULT_BASE),
  parameter int WR_OFFSET    = 64,
  parameter int IRQ_OFFSET   = 128,
  parameter logic [NUM_WR*DATA_WIDTH-1:0] WR_RST_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [ADDR_WIDTH-1:0]        adr_i,
  input  logic [DATA_WIDTH-1:0]        dat_i,
  input  logic                         we_i,
  input  logic [SELECT_WIDTH-1:0]      sel_i,
  input  logic                         stb_i,
  input  logic                         cyc_i,
  output logic [DATA_WIDTH-1:0]        dat_o,
  output logic                         ack_o,
  output logic                         err_o,
  output logic [NUM_WR*DATA_WIDTH-1:0] o_wr_regs,
  output logic [NUM_WR-1:0]            o_wr_stb,
  input  logic [NUM_RD*DATA_WIDTH-1:0] i_rd_regs,
  input  logic [NUM_IRQ-1:0]           i_irq,
  output logic                         o_irq
);

  localparam int unsigned SHIFT = $clog2(SELECT_WIDTH);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_TERM = 1'b1
  } bus_state_t;

  bus_state_t                  state_q, state_d;
  logic                        ack_q, ack_d;
  logic                        err_q, err_d;
  logic [DATA_WIDTH-1:0]       dat_q, dat_d;
  logic [NUM_WR-1:0]           wr_stb_q, wr_stb_d;
  logic [NUM_WR*DATA_WIDTH-1:0] wr_regs_q, wr_regs_d;

  xbus_word_t                  widx;
  xbus_rgn_t                   rgn;
  logic [NUM_WR-1:0]           wr_hit;
  logic [DATA_WIDTH-1:0]       be_mask;
  logic [DATA_WIDTH-1:0]       rd_data;
  logic                        accept;

  logic [NUM_IRQ-1:0]          irq_status;
  logic [NUM_IRQ-1:0]          irq_enable;
  logic [NUM_IRQ-1:0]          irq_clr;
  logic                        irq_en_we;
  logic [NUM_IRQ-1:0]          irq_en_wdata;

  assign widx = word_index(XBUS_IDX_W'(adr_i), XBUS_IDX_W'(BASE_ADDR),
                           ADDR_WIDTH, SHIFT);

  // Region decode plus one-hot hit vector over the control bank.
  always_comb begin
    rgn    = RGN_NONE;
    wr_hit = '0;
    if (widx < xbus_word_t'(NUM_RD)) begin
      rgn = RGN_RD;
    end else if (widx >= xbus_word_t'(WR_OFFSET) &&
                 widx <  xbus_word_t'(WR_OFFSET + NUM_WR)) begin
      rgn = RGN_WR;
    end else if (widx == xbus_word_t'(IRQ_OFFSET)) begin
      rgn = RGN_IRQ_ST;
    end else if (widx == xbus_word_t'(IRQ_OFFSET + 1)) begin
      rgn = RGN_IRQ_EN;
    end
    for (int k = 0; k < NUM_WR; k++) begin
      wr_hit[k] = (widx == xbus_word_t'(WR_OFFSET + k));
    end
  end

  // Expand byte selects into a bit mask for partial writes.
  always_comb begin
    be_mask = '0;
    for (int b = 0; b < SELECT_WIDTH; b++) begin
      be_mask[b*8 +: 8] = {8{sel_i[b]}};
    end
  end

  // Read mux; always returns the full word regardless of byte selects.
  always_comb begin
    rd_data = '0;
    case (rgn)
      RGN_RD: begin
        for (int k = 0; k < NUM_RD; k++) begin
          if (widx == xbus_word_t'(k)) rd_data = i_rd_regs[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      RGN_WR: begin
        for (int k = 0; k < NUM_WR; k++) begin
          if (wr_hit[k]) rd_data = wr_regs_q[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      RGN_IRQ_ST: rd_data[NUM_IRQ-1:0] = irq_status;
      RGN_IRQ_EN: rd_data[NUM_IRQ-1:0] = irq_enable;
      default:    rd_data = '0;
    endcase
  end

  // Byte-lane merge for the enable register, applied only when en_we fires.
  assign irq_en_wdata = (irq_enable & ~be_mask[NUM_IRQ-1:0]) |
                        (dat_i[NUM_IRQ-1:0] & be_mask[NUM_IRQ-1:0]);

  // Terminations are registered, so ack/err never go high two cycles running.
  assign accept = cyc_i & stb_i & ~ack_q & ~err_q & (state_q == ST_IDLE);

  // Bus FSM next state, termination, read capture and write side effects.
  always_comb begin
    state_d   = state_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    dat_d     = dat_q;
    wr_stb_d  = '0;
    wr_regs_d = wr_regs_q;
    irq_clr   = '0;
    irq_en_we = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_TERM;
          if (rgn == RGN_NONE) begin
            err_d = 1'b1;
            dat_d = '0;
          end else begin
            ack_d = 1'b1;
            dat_d = rd_data;
            if (we_i) begin
              case (rgn)
                RGN_WR: begin
                  if (|sel_i) begin
                    for (int k = 0; k < NUM_WR; k++) begin
                      if (wr_hit[k]) begin
                        wr_regs_d[k*DATA_WIDTH +: DATA_WIDTH] =
                          (wr_regs_q[k*DATA_WIDTH +: DATA_WIDTH] & ~be_mask) |
                          (dat_i & be_mask);
                        wr_stb_d[k] = 1'b1;
                      end
                    end
                  end
                end
                RGN_IRQ_ST: irq_clr   = dat_i[NUM_IRQ-1:0] & be_mask[NUM_IRQ-1:0];
                RGN_IRQ_EN: irq_en_we = 1'b1;
                default:    ;
              endcase
            end
          end
        end
      end
      ST_TERM: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus state and control bank; reset drops any access in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      dat_q     <= '0;
      wr_stb_q  <= '0;
      wr_regs_q <= WR_RST_VAL;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      dat_q     <= dat_d;
      wr_stb_q  <= wr_stb_d;
      wr_regs_q <= wr_regs_d;
    end
  end

  sys_xbus_irq_ctrl #(
    .NUM_IRQ(NUM_IRQ)
  ) u_irq_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_i     (i_irq),
    .clr_i     (irq_clr),
    .en_we_i   (irq_en_we),
    .en_wdata_i(irq_en_wdata),
    .status_o  (irq_status),
    .enable_o  (irq_enable),
    .irq_o     (o_irq)
  );

  assign dat_o     = dat_q;
  assign ack_o     = ack_q;
  assign err_o     = err_q;
  assign o_wr_stb  = wr_stb_q;
  assign o_wr_regs = wr_regs_q;

endmodule

// File: tb/tb_sys_xbus_regfile.sv
// Directed bench for the xbus register file.
module tb_sys_xbus_regfile;

  localparam int NUM_RD = 16;
  localparam int NUM_WR = 28;
  localparam int DW     = 32;
  localparam logic [NUM_WR*DW-1:0] RST_VAL = {{(NUM_WR-1){32'h0}}, 32'hA5A5_0001};

  logic                   clk;
  logic                   rst_n;
  logic [31:0]            adr_i;
  logic [31:0]            dat_i;
  logic                   we_i;
  logic [3:0]             sel_i;
  logic                   stb_i;
  logic                   cyc_i;
  logic [31:0]            dat_o;
  logic                   ack_o;
  logic                   err_o;
  logic [NUM_WR*DW-1:0]   o_wr_regs;
  logic [NUM_WR-1:0]      o_wr_stb;
  logic [NUM_RD*DW-1:0]   i_rd_regs;
  logic [7:0]             i_irq;
  logic                   o_irq;

  int checks   = 0;
  int failures = 0;

  logic        r_ack, r_err, r_irq, r_irq2;
  logic [31:0] r_dat;
  logic [NUM_WR-1:0] r_stb, r_stb2;
  logic [NUM_WR*DW-1:0] exp_wr;
  int          n_ack;

  sys_xbus_regfile #(
    .NUM_RD    (NUM_RD),
    .NUM_WR    (NUM_WR),
    .WR_RST_VAL(RST_VAL)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .adr_i    (adr_i),
    .dat_i    (dat_i),
    .we_i     (we_i),
    .sel_i    (sel_i),
    .stb_i    (stb_i),
    .cyc_i    (cyc_i),
    .dat_o    (dat_o),
    .ack_o    (ack_o),
    .err_o    (err_o),
    .o_wr_regs(o_wr_regs),
    .o_wr_stb (o_wr_stb),
    .i_rd_regs(i_rd_regs),
    .i_irq    (i_irq),
    .o_irq    (o_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One single-beat access; captures outputs in the termination cycle and
  // the cycle after it.
  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] s);
    adr_i = a; we_i = w; dat_i = d; sel_i = s; cyc_i = 1'b1; stb_i = 1'b1;
    @(posedge clk); #1;
    r_ack = ack_o; r_err = err_o; r_dat = dat_o; r_stb = o_wr_stb; r_irq = o_irq;
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    @(posedge clk); #1;
    r_stb2 = o_wr_stb; r_irq2 = o_irq;
  endtask

  initial begin
    rst_n = 1'b0; adr_i = '0; dat_i = '0; we_i = 1'b0; sel_i = '0;
    stb_i = 1'b0; cyc_i = 1'b0; i_rd_regs = '0; i_irq = '0;
    i_rd_regs[2*DW +: DW]  = 32'h0000_1234;
    i_rd_regs[15*DW +: DW] = 32'hCAFE_0015;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    chk("rst_ack", ack_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_dat", dat_o, 0);
    chk("rst_irq", o_irq, 0);
    chk("rst_stb", o_wr_stb, 0);
    chk("rst_wr0", o_wr_regs[31:0], 32'hA5A5_0001);

    xfer(32'h1000_0100, 1'b0, 32'h0, 4'hF);
    chk("rd_wr0_ack", r_ack, 1);
    chk("rd_wr0_dat", r_dat, 32'hA5A5_0001);
    chk("rd_wr0_err", r_err, 0);

    xfer(32'h1000_0104, 1'b1, 32'hDEAD_BEEF, 4'b0100);
    chk("wr1_ack", r_ack, 1);
    chk("wr1_stb", r_stb, 28'h000_0002);
    chk("wr1_stb_once", r_stb2, 0);
    chk("wr1_reg", o_wr_regs[63:32], 32'h00AD_0000);
    xfer(32'h1000_0104, 1'b0, 32'h0, 4'h0);
    chk("wr1_readback_sel0", r_dat, 32'h00AD_0000);

    xfer(32'h1000_0008, 1'b0, 32'h0, 4'hF);
    chk("ro2_ack", r_ack, 1);
    chk("ro2_dat", r_dat, 32'h0000_1234);
    xfer(32'h1000_0008, 1'b1, 32'hFFFF_FFFF, 4'hF);
    chk("ro2_wr_ack", r_ack, 1);
    chk("ro2_wr_nostb", r_stb, 0);

    xfer(32'h1000_003C, 1'b0, 32'h0, 4'hF);
    chk("ro15_dat", r_dat, 32'hCAFE_0015);
    xfer(32'h1000_0040, 1'b0, 32'h0, 4'hF);
    chk("ro16_err", r_err, 1);
    chk("ro16_ack", r_ack, 0);

    xfer(32'h1000_016C, 1'b1, 32'h1122_3344, 4'hF);
    chk("wr27_stb", r_stb, 28'h800_0000);
    chk("wr27_reg", o_wr_regs[27*DW +: DW], 32'h1122_3344);
    xfer(32'h1000_0170, 1'b1, 32'hFFFF_FFFF, 4'hF);
    chk("wr28_err", r_err, 1);

    exp_wr = RST_VAL;
    exp_wr[63:32]       = 32'h00AD_0000;
    exp_wr[27*DW +: DW] = 32'h1122_3344;
    xfer(32'h0FFF_FFFC, 1'b1, 32'hFFFF_FFFF, 4'hF);
    chk("below_err", r_err, 1);
    chk("below_ack", r_ack, 0);
    chk("below_dat", r_dat, 0);
    chk("below_stb", r_stb, 0);
    xfer(32'h1000_0400, 1'b1, 32'hFFFF_FFFF, 4'hF);
    chk("hole_err", r_err, 1);
    chk("hole_ack", r_ack, 0);
    chk("hole_dat", r_dat, 0);
    checks++;
    assert (o_wr_regs === exp_wr) else begin
      failures++;
      $error("FAIL wr_regs_unchanged word0=%h word1=%h word27=%h", o_wr_regs[31:0],
             o_wr_regs[63:32], o_wr_regs[27*DW +: DW]);
    end

    xfer(32'h1000_0204, 1'b1, 32'hFFFF_FF08, 4'hF);
    xfer(32'h1000_0204, 1'b0, 32'h0, 4'hF);
    chk("en_readback", r_dat, 32'h0000_0008);
    xfer(32'h1000_0200, 1'b0, 32'h0, 4'hF);
    chk("st_idle", r_dat, 0);
    chk("irq_idle", o_irq, 0);

    i_irq = 8'h08;
    @(posedge clk); #1;
    i_irq = 8'h00;
    chk("irq_lag", o_irq, 0);
    @(posedge clk); #1;
    chk("irq_set", o_irq, 1);
    xfer(32'h1000_0200, 1'b0, 32'h0, 4'hF);
    chk("st_set", r_dat, 32'h0000_0008);
    xfer(32'h1000_0200, 1'b0, 32'h0, 4'hF);
    chk("st_nondestructive", r_dat, 32'h0000_0008);

    i_irq = 8'h08;
    adr_i = 32'h1000_0200; we_i = 1'b1; dat_i = 32'h8; sel_i = 4'hF;
    cyc_i = 1'b1; stb_i = 1'b1;
    @(posedge clk); #1;
    i_irq = 8'h00;
    chk("w1c_race_ack", ack_o, 1);
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    @(posedge clk); #1;
    xfer(32'h1000_0200, 1'b0, 32'h0, 4'hF);
    chk("w1c_race_st", r_dat, 32'h0000_0008);
    chk("w1c_race_irq", o_irq, 1);

    xfer(32'h1000_0200, 1'b1, 32'h8, 4'hF);
    chk("w1c_irq_lag", r_irq, 1);
    chk("w1c_irq_clr", r_irq2, 0);
    xfer(32'h1000_0200, 1'b0, 32'h0, 4'hF);
    chk("w1c_st", r_dat, 0);

    adr_i = 32'h1000_0100; we_i = 1'b0; sel_i = 4'hF; stb_i = 1'b1; cyc_i = 1'b0;
    @(posedge clk); #1;
    chk("nocyc_ack", ack_o, 0);
    cyc_i = 1'b1;
    n_ack = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ack_o) n_ack++;
    end
    cyc_i = 1'b0; stb_i = 1'b0;
    chk("held_acks", n_ack, 3);
    @(posedge clk); #1;

    adr_i = 32'h1000_0104; we_i = 1'b1; dat_i = 32'hFFFF_FFFF; sel_i = 4'hF;
    cyc_i = 1'b1; stb_i = 1'b1; rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rstacc_ack", ack_o, 0);
    chk("rstacc_stb", o_wr_stb, 0);
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rstacc_wr1", o_wr_regs[63:32], 0);
    chk("rstacc_wr0", o_wr_regs[31:0], 32'hA5A5_0001);
    chk("rstacc_wr27", o_wr_regs[27*DW +: DW], 0);
    xfer(32'h1000_0204, 1'b0, 32'h0, 4'hF);
    chk("rstacc_en", r_dat, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
